// File: rtl/maxpool_2_if.sv
// Handshake and RAM-port bundle between the pooling stage and its surroundings.
// The slave side is the pooling engine; the master side is the RAMs and the sequencer.
interface maxpool_2_if #(
    parameter int DATA_W     = 32,
    parameter int IN_ADDR_W  = 14,
    parameter int OUT_ADDR_W = 14
);
    logic                         start;
    logic signed [DATA_W-1:0]     in_data;
    logic        [IN_ADDR_W-1:0]  in_addr;
    logic        [OUT_ADDR_W-1:0] out_addr;
    logic signed [DATA_W-1:0]     out_data;
    logic                         out_wren;
    logic                         busy;
    logic                         ready;

    modport slave (
        input  start, in_data,
        output in_addr, out_addr, out_data, out_wren, busy, ready
    );

    modport master (
        output start, in_data,
        input  in_addr, out_addr, out_data, out_wren, busy, ready
    );
endinterface

// File: rtl/maxpool_2.sv
// 2x2 stride-2 max-pool over CHANNELS feature maps of IN_DIM x IN_DIM signed samples.
// Each tap address is held for RD_LAT+1 cycles so the RAM data is sampled once it is valid.
module maxpool_2 #(
    parameter int CHANNELS   = 10,
    parameter int IN_DIM     = 10,
    parameter int DATA_W     = 32,
    parameter int IN_ADDR_W  = 14,
    parameter int OUT_ADDR_W = 14,
    parameter int RD_LAT     = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    maxpool_2_if.slave bus
);
    localparam int OUT_DIM = IN_DIM / 2;
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int POS_W   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    // state   | meaning
    // S_IDLE  | waiting for start
    // S_FETCH | holding a tap address, sampling it at wait count RD_LAT
    // S_WRITE | writing the finished window max
    // S_DONE  | one-cycle ready pulse, then back to idle
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_DONE} state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [CH_W-1:0]          r_ch;
    logic [POS_W-1:0]         r_orow;
    logic [POS_W-1:0]         r_ocol;
    logic [1:0]               r_tap;
    logic [2:0]               r_wait;
    logic signed [DATA_W-1:0] r_max;

    logic                     w_sample;
    logic                     w_last_ocol;
    logic                     w_last_orow;
    logic                     w_last_ch;
    logic                     w_wren;
    logic                     w_busy;
    logic                     w_ready;
    logic [IN_ADDR_W-1:0]     w_in_row;
    logic [IN_ADDR_W-1:0]     w_in_col;

    assign w_sample    = (r_state == S_FETCH) && (r_wait == 3'(RD_LAT));
    assign w_last_ocol = (r_ocol == POS_W'(OUT_DIM - 1));
    assign w_last_orow = (r_orow == POS_W'(OUT_DIM - 1));
    assign w_last_ch   = (r_ch == CH_W'(CHANNELS - 1));

    assign w_in_row = IN_ADDR_W'({r_orow, 1'b0}) + IN_ADDR_W'(r_tap[1]);
    assign w_in_col = IN_ADDR_W'({r_ocol, 1'b0}) + IN_ADDR_W'(r_tap[0]);

    assign bus.in_addr  = IN_ADDR_W'(r_ch) * IN_ADDR_W'(IN_DIM * IN_DIM)
                        + w_in_row * IN_ADDR_W'(IN_DIM) + w_in_col;
    assign bus.out_addr = OUT_ADDR_W'(r_ch) * OUT_ADDR_W'(OUT_DIM * OUT_DIM)
                        + OUT_ADDR_W'(r_orow) * OUT_ADDR_W'(OUT_DIM) + OUT_ADDR_W'(r_ocol);
    assign bus.out_data = r_max;
    assign bus.out_wren = w_wren && !Reset;
    assign bus.busy     = w_busy;
    assign bus.ready    = w_ready;

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_wren  = 1'b0;
        w_busy  = 1'b1;
        w_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) w_next = S_FETCH;
            end
            S_FETCH: begin
                if (w_sample && (r_tap == 2'd3)) w_next = S_WRITE;
            end
            S_WRITE: begin
                w_wren = 1'b1;
                w_next = (w_last_ch && w_last_orow && w_last_ocol) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                w_ready = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ch   <= '0;
            r_orow <= '0;
            r_ocol <= '0;
            r_tap  <= '0;
            r_wait <= '0;
            r_max  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_ch   <= '0;
                        r_orow <= '0;
                        r_ocol <= '0;
                        r_tap  <= '0;
                        r_wait <= '0;
                    end
                end
                S_FETCH: begin
                    if (w_sample) begin
                        // Tap 0 seeds the window; strict compare keeps the earlier value on ties.
                        if ((r_tap == 2'd0) || (bus.in_data > r_max)) r_max <= bus.in_data;
                        r_wait <= '0;
                        r_tap  <= r_tap + 2'd1;
                    end else begin
                        r_wait <= r_wait + 3'd1;
                    end
                end
                S_WRITE: begin
                    if (w_last_ocol) begin
                        r_ocol <= '0;
                        if (w_last_orow) begin
                            r_orow <= '0;
                            r_ch   <= w_last_ch ? '0 : r_ch + CH_W'(1);
                        end else begin
                            r_orow <= r_orow + POS_W'(1);
                        end
                    end else begin
                        r_ocol <= r_ocol + POS_W'(1);
                    end
                end
                S_DONE: begin
                    r_ch   <= '0;
                    r_orow <= '0;
                    r_ocol <= '0;
                    r_tap  <= '0;
                    r_wait <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
